axi_writeback_buffer: RTL and testbench

AXI_WRITEBACK_BUFFER -- requirements
Module: axi_writeback_buffer

---
 rtl/axi_wb_pkg.sv | 24 ++
 rtl/wb_line_buf.sv | 44 ++++
 rtl/axi_writeback_buffer.sv | 232 +++++++++++++++++++++++
 tb/tb_axi_writeback_buffer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_wb_pkg.sv
// Shared types and constants for the AXI write-back buffer.
//   wb_state_e      : buffer FSM states
//   AXI_BURST_INCR  : incrementing burst encoding
//   AXI_SIZE_4B     : 4-byte beat size encoding
//   AXI_RESP_OKAY   : OKAY write response
package axi_wb_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned LINE_OFF_W = 5;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_AW   = 3'd2,
    ST_W    = 3'd3,
    ST_B    = 3'd4
  } wb_state_e;

endpackage

// File: rtl/wb_line_buf.sv
// Single cache-line store with one write port and two word read muxes.
//   clk        : clock
//   wr_en      : load the whole line from wr_line
//   wr_line    : line data, word0 in bits [31:0]
//   rd_idx_a   : word index for the burst data path
//   rd_data_a  : selected word (combinational)
//   rd_idx_b   : word index for the forwarding path
//   rd_data_b  : selected word (combinational)
module wb_line_buf
  import axi_wb_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 8,
  localparam int unsigned IDX_W = $clog2(LINE_WORDS)
) (
  input  logic                         clk,
  input  logic                         wr_en,
  input  logic [WORD_W*LINE_WORDS-1:0] wr_line,
  input  logic [IDX_W-1:0]             rd_idx_a,
  output logic [WORD_W-1:0]            rd_data_a,
  input  logic [IDX_W-1:0]             rd_idx_b,
  output logic [WORD_W-1:0]            rd_data_b
);

  logic [WORD_W-1:0] mem_q [LINE_WORDS];
  logic [WORD_W-1:0] mem_d [LINE_WORDS];

  // Whole-line load; contents are don't-care until the first capture.
  always_comb begin : line_next
    for (int i = 0; i < int'(LINE_WORDS); i++) begin
      mem_d[i] = mem_q[i];
      if (wr_en) begin
        mem_d[i] = wr_line[WORD_W*i +: WORD_W];
      end
    end
  end

  always_ff @(posedge clk) begin : line_reg
    mem_q <= mem_d;
  end

  assign rd_data_a = mem_q[rd_idx_a];
  assign rd_data_b = mem_q[rd_idx_b];

endmodule

// File: rtl/axi_writeback_buffer.sv
// One-line write-back buffer draining dirty dcache lines as AXI INCR bursts.
// Optional store-to-load forwarding is built when WB_FORWARD_EN is defined.
//   clk, rst                 : clock, async active-high reset
//   wb_valid/wb_ready        : line handoff from the dcache (addr + data)
//   wb_err                   : one-cycle pulse after a non-OKAY response
//   lookup_addr/hit/data     : combinational probe of the buffered line
//   req/grnt                 : store-bus arbitration
//   aw*, w*, b*              : AXI3 write channels
module axi_writeback_buffer
  import axi_wb_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 8,
  parameter logic [3:0]  AXI_ID     = 4'd1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wb_valid,
  output logic                         wb_ready,
  input  logic [ADDR_W-1:0]            wb_addr,
  input  logic [WORD_W*LINE_WORDS-1:0] wb_data,
  output logic                         wb_err,
  input  logic [ADDR_W-1:0]            lookup_addr,
  output logic                         lookup_hit,
  output logic [WORD_W-1:0]            lookup_data,
  output logic                         req,
  input  logic                         grnt,
  output logic [3:0]                   awid,
  output logic [3:0]                   awlen,
  output logic [2:0]                   awsize,
  output logic [1:0]                   awburst,
  output logic [1:0]                   awlock,
  output logic [3:0]                   awcache,
  output logic [2:0]                   awprot,
  output logic [ADDR_W-1:0]            awaddr,
  output logic                         awvalid,
  input  logic                         awready,
  output logic [3:0]                   wid,
  output logic [WORD_W-1:0]            wdata,
  output logic [3:0]                   wstrb,
  output logic                         wlast,
  output logic                         wvalid,
  input  logic                         wready,
  input  logic [3:0]                   bid,
  input  logic [1:0]                   bresp,
  input  logic                         bvalid,
  output logic                         bready
);

  localparam int unsigned       BEAT_W    = $clog2(LINE_WORDS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
  localparam logic [3:0]        AW_LEN    = 4'(LINE_WORDS - 1);

  wb_state_e           state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                cap_en;

  logic                wb_ready_q, wb_ready_d;
  logic                wb_err_q, wb_err_d;
  logic                req_q, req_d;
  logic                awvalid_q, awvalid_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [3:0]          awlen_q, awlen_d;
  logic [2:0]          awsize_q, awsize_d;
  logic [1:0]          awburst_q, awburst_d;
  logic [3:0]          awid_q, awid_d;
  logic                wvalid_q, wvalid_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic                wlast_q, wlast_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic [3:0]          wid_q, wid_d;
  logic                bready_q, bready_d;

  logic [WORD_W-1:0]   beat_word;
  logic [WORD_W-1:0]   lookup_word;

  // Burst reads index with the next beat so wdata can be registered.
  wb_line_buf #(
    .LINE_WORDS (LINE_WORDS)
  ) u_line_buf (
    .clk       (clk),
    .wr_en     (cap_en),
    .wr_line   (wb_data),
    .rd_idx_a  (beat_d),
    .rd_data_a (beat_word),
    .rd_idx_b  (lookup_addr[BEAT_W+1:2]),
    .rd_data_b (lookup_word)
  );

  // Next-state: handoff, arbitration, AW, W beats, B response.
  always_comb begin : fsm_next
    state_d  = state_q;
    beat_d   = beat_q;
    addr_d   = addr_q;
    cap_en   = 1'b0;
    wb_err_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (wb_valid && wb_ready_q) begin
          cap_en  = 1'b1;
          addr_d  = {wb_addr[ADDR_W-1:LINE_OFF_W], LINE_OFF_W'(0)};
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (grnt) begin
          state_d = ST_AW;
        end
      end
      ST_AW: begin
        if (awready) begin
          beat_d  = '0;
          state_d = ST_W;
        end
      end
      ST_W: begin
        if (wready) begin
          // Beat saturates on the last word instead of wrapping.
          if (beat_q == LAST_BEAT) begin
            state_d = ST_B;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      ST_B: begin
        if (bvalid) begin
          wb_err_d = (bresp != AXI_RESP_OKAY);
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        beat_d  = '0;
      end
    endcase
  end

  // Output next values decode the upcoming state; payloads are 0 when idle.
  always_comb begin : out_next
    wb_ready_d = (state_d == ST_IDLE);
    req_d      = (state_d != ST_IDLE);
    awvalid_d  = (state_d == ST_AW);
    awaddr_d   = awvalid_d ? addr_d : '0;
    awlen_d    = awvalid_d ? AW_LEN : '0;
    awsize_d   = awvalid_d ? AXI_SIZE_4B : '0;
    awburst_d  = awvalid_d ? AXI_BURST_INCR : '0;
    awid_d     = awvalid_d ? AXI_ID : '0;
    wvalid_d   = (state_d == ST_W);
    wdata_d    = wvalid_d ? beat_word : '0;
    wlast_d    = wvalid_d && (beat_d == LAST_BEAT);
    wstrb_d    = wvalid_d ? 4'hF : 4'h0;
    wid_d      = wvalid_d ? AXI_ID : '0;
    bready_d   = (state_d == ST_B);
  end

  always_ff @(posedge clk or posedge rst) begin : regs
    if (rst) begin
      state_q    <= ST_IDLE;
      beat_q     <= '0;
      addr_q     <= '0;
      wb_ready_q <= 1'b1;
      wb_err_q   <= 1'b0;
      req_q      <= 1'b0;
      awvalid_q  <= 1'b0;
      awaddr_q   <= '0;
      awlen_q    <= '0;
      awsize_q   <= '0;
      awburst_q  <= '0;
      awid_q     <= '0;
      wvalid_q   <= 1'b0;
      wdata_q    <= '0;
      wlast_q    <= 1'b0;
      wstrb_q    <= '0;
      wid_q      <= '0;
      bready_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      addr_q     <= addr_d;
      wb_ready_q <= wb_ready_d;
      wb_err_q   <= wb_err_d;
      req_q      <= req_d;
      awvalid_q  <= awvalid_d;
      awaddr_q   <= awaddr_d;
      awlen_q    <= awlen_d;
      awsize_q   <= awsize_d;
      awburst_q  <= awburst_d;
      awid_q     <= awid_d;
      wvalid_q   <= wvalid_d;
      wdata_q    <= wdata_d;
      wlast_q    <= wlast_d;
      wstrb_q    <= wstrb_d;
      wid_q      <= wid_d;
      bready_q   <= bready_d;
    end
  end

  assign wb_ready = wb_ready_q;
  assign wb_err   = wb_err_q;
  assign req      = req_q;
  assign awvalid  = awvalid_q;
  assign awaddr   = awaddr_q;
  assign awlen    = awlen_q;
  assign awsize   = awsize_q;
  assign awburst  = awburst_q;
  assign awid     = awid_q;
  assign awlock   = '0;
  assign awcache  = '0;
  assign awprot   = '0;
  assign wvalid   = wvalid_q;
  assign wdata    = wdata_q;
  assign wlast    = wlast_q;
  assign wstrb    = wstrb_q;
  assign wid      = wid_q;
  assign bready   = bready_q;

  // Forwarding probe: combinational hit on the captured line while it is held.
`ifdef WB_FORWARD_EN
  assign lookup_hit  = (state_q != ST_IDLE) &&
                       (lookup_addr[ADDR_W-1:LINE_OFF_W] == addr_q[ADDR_W-1:LINE_OFF_W]);
  assign lookup_data = lookup_word;
`else
  assign lookup_hit  = 1'b0;
  assign lookup_data = '0;
`endif

  // Inputs intentionally not consumed: response ID, line offset bits.
  logic unused_inputs;
  assign unused_inputs = ^{bid, wb_addr[LINE_OFF_W-1:0], lookup_addr, lookup_word};

endmodule

// File: tb/tb_axi_writeback_buffer.sv
// Directed + randomized bench for axi_writeback_buffer with a queue-based
// reference model of the burst each captured line must produce.
module tb_axi_writeback_buffer;

  localparam int unsigned LW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            wb_valid;
  logic            wb_ready;
  logic [31:0]     wb_addr;
  logic [32*LW-1:0] wb_data;
  logic            wb_err;
  logic [31:0]     lookup_addr;
  logic            lookup_hit;
  logic [31:0]     lookup_data;
  logic            req;
  logic            grnt;
  logic [3:0]      awid;
  logic [3:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic [1:0]      awlock;
  logic [3:0]      awcache;
  logic [2:0]      awprot;
  logic [31:0]     awaddr;
  logic            awvalid;
  logic            awready;
  logic [3:0]      wid;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;
  logic [3:0]      bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  axi_writeback_buffer #(.LINE_WORDS(LW), .AXI_ID(4'd1)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_err(wb_err),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
    .req(req), .grnt(grnt),
    .awid(awid), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
    .awcache(awcache), .awprot(awprot), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, 64'({req, awvalid, wvalid, wlast, bready, wb_err, awlen, awsize, awburst,
                            awlock, awcache, awprot, awid, wid, wstrb}), 64'd0);
    chk({tag, "_awaddr"}, 64'(awaddr), 64'd0);
    chk({tag, "_wdata"}, 64'(wdata), 64'd0);
    chk({tag, "_wb_ready"}, 64'(wb_ready), 64'd1);
  endtask

  // One full line: handoff, arbitration, AW (optional stall), W per wmode
  // (0 = always ready, 1 = 1,0,0,1 pattern, 2 = random), B with resp.
  // abort_beat >= 0 pulses rst after that many W beats were accepted.
  task automatic do_line(input logic [31:0] addr, input bit fixed, input int gdelay,
                         input int awstall, input int wmode, input logic [1:0] resp,
                         input int abort_beat);
    logic [31:0] w [LW];
    logic [31:0] q [$];
    logic [31:0] base;
    int          cyc;
    int          beats;
    int          bdelay;
    logic        wr;
    bit          pat [4];
    pat  = '{1'b1, 1'b0, 1'b0, 1'b1};
    base = addr & 32'hFFFF_FFE0;
    for (int i = 0; i < int'(LW); i++) w[i] = fixed ? 32'hA0 + 32'(i) : $urandom;

    // handoff
    #1 chk("idle_wb_ready", 64'(wb_ready), 64'd1);
    chk("idle_lookup_hit", 64'(lookup_hit), 64'd0);
    wb_valid = 1'b1;
    wb_addr  = addr;
    for (int i = 0; i < int'(LW); i++) wb_data[32*i +: 32] = w[i];
    @(negedge clk);
    wb_valid = 1'b0;
    wb_data  = {LW{32'hDEAD_BEEF}};
    wb_addr  = $urandom;

    // arbitration
    for (int k = 0; k < gdelay; k++) begin
      grnt = 1'b0;
      #1 chk("req_wait_req", 64'(req), 64'd1);
      chk("req_wait_awvalid", 64'(awvalid), 64'd0);
      chk("req_wait_wb_ready", 64'(wb_ready), 64'd0);
      @(negedge clk);
    end
    grnt = 1'b1;
    #1 chk("req_req", 64'(req), 64'd1);
    chk("req_awvalid", 64'(awvalid), 64'd0);
    @(negedge clk);

    // address phase
    for (int s = 0; s <= awstall; s++) begin
      grnt    = 1'($urandom);
      awready = (s == awstall);
      #1 chk("aw_awvalid", 64'(awvalid), 64'd1);
      chk("aw_awaddr", 64'(awaddr), 64'(base));
      chk("aw_awlen", 64'(awlen), 64'(LW - 1));
      chk("aw_fields", 64'({awsize, awburst, awid, awlock, awcache, awprot}),
          64'({3'b010, 2'b01, 4'd1, 2'b00, 4'd0, 3'd0}));
      chk("aw_wvalid", 64'(wvalid), 64'd0);
      @(negedge clk);
    end
    awready = 1'b0;

    // data phase against the expected word queue
    q = {};
    for (int i = 0; i < int'(LW); i++) q.push_back(w[i]);
    cyc   = 0;
    beats = 0;
    while (q.size() > 0 && cyc < 200) begin
      if (beats == abort_beat) begin
        rst = 1'b1;
        #1 chk_all_zero("abort");
        @(negedge clk);
        rst    = 1'b0;
        wready = 1'b0;
        #1 chk("abort_req", 64'(req), 64'd0);
        @(negedge clk);
        return;
      end
      grnt = 1'($urandom);
      case (wmode)
        0:       wr = 1'b1;
        1:       wr = pat[cyc % 4];
        default: wr = 1'($urandom);
      endcase
      wready = wr;
      if (cyc == 0) begin
        lookup_addr = base + 32'h18;
        #1;
`ifdef WB_FORWARD_EN
        chk("fwd_hit", 64'(lookup_hit), 64'd1);
        chk("fwd_data", 64'(lookup_data), 64'(w[6]));
`else
        chk("fwd_hit_off", 64'(lookup_hit), 64'd0);
        chk("fwd_data_off", 64'(lookup_data), 64'd0);
`endif
        lookup_addr = base + 32'h20;
        #1 chk("fwd_miss", 64'(lookup_hit), 64'd0);
      end
      #1 chk("w_wvalid", 64'(wvalid), 64'd1);
      chk("w_wdata", 64'(wdata), 64'(q[0]));
      chk("w_wlast", 64'(wlast), 64'(q.size() == 1));
      chk("w_strb_id", 64'({wstrb, wid}), 64'({4'hF, 4'd1}));
      chk("w_awvalid", 64'(awvalid), 64'd0);
      @(negedge clk);
      if (wr) begin
        void'(q.pop_front());
        beats++;
      end
      cyc++;
    end
    chk("w_all_beats_done", 64'(q.size()), 64'd0);
    wready = 1'b0;

    // response phase; a new offer during the handshake must not be taken
    bdelay = int'($urandom_range(2, 0));
    for (int k = 0; k < bdelay; k++) begin
      #1 chk("b_wait_bready", 64'(bready), 64'd1);
      chk("b_wait_wvalid", 64'(wvalid), 64'd0);
      chk("b_wait_wb_err", 64'(wb_err), 64'd0);
      @(negedge clk);
    end
    bvalid   = 1'b1;
    bresp    = resp;
    bid      = 4'($urandom);
    wb_valid = 1'b1;
    #1 chk("b_bready", 64'(bready), 64'd1);
    chk("b_wb_ready", 64'(wb_ready), 64'd0);
    @(negedge clk);
    bvalid   = 1'b0;
    wb_valid = 1'b0;
    #1 chk("post_b_wb_err", 64'(wb_err), 64'(resp != 2'b00));
    chk("post_b_wb_ready", 64'(wb_ready), 64'd1);
    chk("post_b_req", 64'(req), 64'd0);
    chk("post_b_bready", 64'(bready), 64'd0);
    @(negedge clk);
    #1 chk("err_one_cycle", 64'(wb_err), 64'd0);
    chk("no_early_accept", 64'(req), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    rst         = 1'b1;
    wb_valid    = 1'b0;
    wb_addr     = '0;
    wb_data     = '0;
    lookup_addr = '0;
    grnt        = 1'b0;
    awready     = 1'b0;
    wready      = 1'b0;
    bid         = '0;
    bresp       = '0;
    bvalid      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 chk_all_zero("reset");
    chk("reset_lookup", 64'(lookup_hit), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    do_line(32'h1000_0014, 1'b1, 0, 0, 0, 2'b00, -1);
    do_line($urandom, 1'b0, 10, 0, 0, 2'b00, -1);
    do_line($urandom, 1'b0, 0, 0, 1, 2'b00, -1);
    do_line($urandom, 1'b0, 0, 0, 0, 2'b10, -1);
    do_line($urandom, 1'b0, 2, 3, 2, 2'b00, -1);
    do_line(32'h1000_0000, 1'b1, 0, 0, 0, 2'b00, 3);
    do_line($urandom, 1'b0, 0, 0, 0, 2'b00, -1);
    for (int n = 0; n < 4; n++) begin
      do_line($urandom, 1'b0, int'($urandom_range(3, 0)), int'($urandom_range(2, 0)),
              int'($urandom_range(2, 0)), 2'($urandom), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
